// File: rtl/ir_fmt_pkg.sv
// Shared instruction-register format: field bit positions, field-select
// codes, encoder state encoding and the signed-constant range helper.
package ir_fmt_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;
  localparam int C_MSB   = 18;
  localparam int C_LSB   = 0;

  typedef enum logic [1:0] {
    FIELD_OPC = 2'b00,
    FIELD_RA  = 2'b01,
    FIELD_RB  = 2'b10,
    FIELD_RC  = 2'b11
  } field_sel_e;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } enc_state_e;

  // A 32-bit constant fits the 19-bit signed C field when bits [31:18] are all equal.
  function automatic logic const_fits(input logic [31:0] value);
    return (&value[31:18]) || !(|value[31:18]);
  endfunction

endpackage

// File: rtl/onehot16_to_bin4.sv
// Converts a 16-bit one-hot register select to its 4-bit index; the highest
// set bit wins, and 'invalid' flags zero or multiple set bits.
module onehot16_to_bin4 (
  input  logic [15:0] onehot,
  output logic [3:0]  index,
  output logic        invalid
);

  always_comb begin
    index = '0;
    for (int i = 0; i < 16; i++) begin
      if (onehot[i]) index = 4'(i);
    end
  end

  assign invalid = (onehot == '0) || ((onehot & (onehot - 16'd1)) != '0);

endmodule

// File: rtl/ir_encoder.sv
// Assembles an instruction word from field beats and hands it downstream.
// Optional macro IR_ENC_CHECK_EN enables one-hot and constant-range checking.
module ir_encoder
  import ir_fmt_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  field_sel,
  input  logic        use_const,
  input  logic [4:0]  opcode_in,
  input  logic [15:0] reg_onehot,
  input  logic [31:0] const_in,
  input  logic        last,
  output logic [31:0] ir_out,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        err_out
);

`ifdef IR_ENC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  enc_state_e  state;
  logic [31:0] work_word;
  logic [31:0] next_word;
  logic        err_flag;
  logic        beat_err;
  logic [3:0]  bin_idx;
  logic [3:0]  reg_idx;
  logic        reg_bad;

  onehot16_to_bin4 u_onehot (
    .onehot  (reg_onehot),
    .index   (bin_idx),
    .invalid (reg_bad)
  );

  // Working word with the current beat's field merged in, plus that beat's error.
  always_comb begin
    next_word = work_word;
    beat_err  = 1'b0;
    reg_idx   = (CHECK_EN && reg_bad) ? 4'd0 : bin_idx;
    case (field_sel_e'(field_sel))
      FIELD_OPC: next_word[OPC_MSB:OPC_LSB] = opcode_in;
      FIELD_RA: begin
        next_word[RA_MSB:RA_LSB] = reg_idx;
        beat_err = CHECK_EN && reg_bad;
      end
      FIELD_RB: begin
        next_word[RB_MSB:RB_LSB] = reg_idx;
        beat_err = CHECK_EN && reg_bad;
      end
      FIELD_RC: begin
        if (use_const) begin
          next_word[C_MSB:C_LSB] = const_in[18:0];
          beat_err = CHECK_EN && !const_fits(const_in);
        end else begin
          next_word[RC_MSB:RC_LSB]  = reg_idx;
          next_word[RC_LSB-1:C_LSB] = '0;
          beat_err = CHECK_EN && reg_bad;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= COLLECT;
      work_word <= '0;
      err_flag  <= 1'b0;
      ir_valid  <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid) begin
            work_word <= next_word;
            err_flag  <= err_flag | beat_err;
            if (last) begin
              state    <= EMIT;
              ir_valid <= 1'b1;
              in_ready <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (ir_ready) begin
            state     <= COLLECT;
            work_word <= '0;
            err_flag  <= 1'b0;
            ir_valid  <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign ir_out  = work_word;
  assign err_out = CHECK_EN & err_flag;

endmodule

// File: tb/tb_ir_encoder.sv
// Directed self-checking bench for ir_encoder; expectations follow the
// IR_ENC_CHECK_EN setting of the build.
module tb_ir_encoder;

`ifdef IR_ENC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  field_sel = 2'b00;
  logic        use_const = 1'b0;
  logic [4:0]  opcode_in = '0;
  logic [15:0] reg_onehot = '0;
  logic [31:0] const_in = '0;
  logic        last = 1'b0;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        err_out;

  int checks = 0;
  int failures = 0;

  ir_encoder dut (
    .clock      (clock),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .field_sel  (field_sel),
    .use_const  (use_const),
    .opcode_in  (opcode_in),
    .reg_onehot (reg_onehot),
    .const_in   (const_in),
    .last       (last),
    .ir_out     (ir_out),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .err_out    (err_out)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One field beat, driven at the falling edge and settled #1 after the rising edge.
  task automatic apply_stimulus(input logic [1:0] sel, input logic uc,
                                input logic [4:0] opc, input logic [15:0] oh,
                                input logic [31:0] c, input logic lst);
    @(negedge clock);
    field_sel  = sel;
    use_const  = uc;
    opcode_in  = opc;
    reg_onehot = oh;
    const_in   = c;
    last       = lst;
    in_valid   = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  task automatic check_emit(input string tag, input logic [31:0] word, input logic err);
    check_output({tag, "_valid"}, {31'd0, ir_valid}, 32'd1);
    check_output({tag, "_word"}, ir_out, word);
    check_output({tag, "_err"}, {31'd0, err_out}, {31'd0, err});
    check_output({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic accept_word(input string tag);
    @(negedge clock);
    ir_ready = 1'b1;
    @(posedge clock);
    #1;
    ir_ready = 1'b0;
    check_output({tag, "_done_valid"}, {31'd0, ir_valid}, 32'd0);
    check_output({tag, "_done_in_ready"}, {31'd0, in_ready}, 32'd1);
    check_output({tag, "_done_word"}, ir_out, 32'd0);
  endtask

  initial begin
    #12;
    check_output("rst_valid", {31'd0, ir_valid}, 32'd0);
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("rst_word", ir_out, 32'd0);
    check_output("rst_err", {31'd0, err_out}, 32'd0);
    @(negedge clock);
    clear = 1'b1;

    // Basic instruction: opcode 3, Ra=R4, Rb=R9, C=-5
    apply_stimulus(2'b00, 1'b0, 5'b00011, 16'h0000, 32'h0, 1'b0);
    apply_stimulus(2'b01, 1'b0, 5'b00000, 16'h0010, 32'h0, 1'b0);
    apply_stimulus(2'b10, 1'b0, 5'b00000, 16'h0200, 32'h0, 1'b0);
    check_output("basic_pre_valid", {31'd0, ir_valid}, 32'd0);
    apply_stimulus(2'b11, 1'b1, 5'b00000, 16'h0000, 32'hFFFF_FFFB, 1'b1);
    check_emit("basic", 32'h1A4F_FFFB, 1'b0);
    accept_word("basic");

    // Multi-hot Rb select
    apply_stimulus(2'b10, 1'b0, 5'b00000, 16'h0028, 32'h0, 1'b1);
    check_emit("multihot", CHK ? 32'h0 : 32'h0028_0000, CHK);
    accept_word("multihot");

    // Zero Ra select
    apply_stimulus(2'b01, 1'b0, 5'b00000, 16'h0000, 32'h0, 1'b1);
    check_emit("zerohot", 32'h0, CHK);
    accept_word("zerohot");

    // Constant just above range
    apply_stimulus(2'b11, 1'b1, 5'b00000, 16'h0000, 32'h0004_0000, 1'b1);
    check_emit("c_over", 32'h0004_0000, CHK);
    accept_word("c_over");

    // Constant range edges: -2^18 and 2^18-1
    apply_stimulus(2'b11, 1'b1, 5'b00000, 16'h0000, 32'hFFFC_0000, 1'b1);
    check_emit("c_min", 32'h0004_0000, 1'b0);
    accept_word("c_min");
    apply_stimulus(2'b11, 1'b1, 5'b00000, 16'h0000, 32'h0003_FFFF, 1'b1);
    check_emit("c_max", 32'h0003_FFFF, 1'b0);
    accept_word("c_max");

    // Overwrites: Ra R1 then R15; C then Rc R3 clears the low 15 bits
    apply_stimulus(2'b01, 1'b0, 5'b00000, 16'h0002, 32'h0, 1'b0);
    apply_stimulus(2'b11, 1'b1, 5'b00000, 16'h0000, 32'h0001_2345, 1'b0);
    apply_stimulus(2'b01, 1'b0, 5'b00000, 16'h8000, 32'h0, 1'b0);
    apply_stimulus(2'b11, 1'b0, 5'b00000, 16'h0008, 32'h0, 1'b1);
    check_emit("overwrite", 32'h0781_8000, 1'b0);
    accept_word("overwrite");

    // Backpressure: EMIT holds while in_valid toggles
    apply_stimulus(2'b00, 1'b0, 5'b00011, 16'h0000, 32'h0, 1'b1);
    check_emit("hold0", 32'h1800_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      field_sel = 2'b00;
      opcode_in = 5'b11111;
      last      = 1'b1;
      in_valid  = ~in_valid;
      @(posedge clock);
      #1;
      check_emit($sformatf("hold%0d", i + 1), 32'h1800_0000, 1'b0);
    end
    in_valid = 1'b0;
    last     = 1'b0;
    accept_word("hold");

    // Reset mid-collection discards the partial word
    apply_stimulus(2'b00, 1'b0, 5'b11111, 16'h0000, 32'h0, 1'b0);
    apply_stimulus(2'b01, 1'b0, 5'b00000, 16'h0004, 32'h0, 1'b0);
    @(negedge clock);
    clear = 1'b0;
    #2;
    check_output("midrst_word", ir_out, 32'd0);
    check_output("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    clear = 1'b1;
    apply_stimulus(2'b00, 1'b0, 5'b00001, 16'h0000, 32'h0, 1'b1);
    check_emit("after_rst", 32'h0800_0000, 1'b0);

    // Reset mid-EMIT drops the pending word
    @(negedge clock);
    clear = 1'b0;
    #2;
    check_output("emitrst_valid", {31'd0, ir_valid}, 32'd0);
    check_output("emitrst_word", ir_out, 32'd0);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    check_output("emitrst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
